// File: rtl/knight_ctrl.sv
// Knight-rider LED sequencer: one-hot pattern stepped every P+1 cycles
// in bounce / wrap-left / wrap-right / hold modes, with a command port.
module knight_ctrl #(
  parameter logic [15:0] RESET_PERIOD = 16'd9
) (
  input  logic        ck,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [7:0]  out,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PERIOD = 2'b10;
  localparam logic [1:0] OP_MODE   = 2'b11;

  localparam logic [1:0] M_BOUNCE = 2'b00;
  localparam logic [1:0] M_WRAPL  = 2'b01;
  localparam logic [1:0] M_WRAPR  = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] p;
  logic [15:0] n;
  logic [15:0] sweeps;
  logic [15:0] pend_p;
  logic [1:0]  mode;
  logic [1:0]  pend_m;
  logic        up;
  logic        pend_p_v;
  logic        pend_m_v;

  logic        acc;
  logic        tick;
  logic [7:0]  nxt_out;
  logic        nxt_up;
  logic        swept;

  assign busy      = (state == RUN);
  assign cmd_ready = !(pend_p_v || pend_m_v);
  assign acc       = cmd_valid && cmd_ready;
  assign tick      = (state == RUN) && (cnt == p);

  // Next pattern for a tick, and whether that step closes a sweep
  always_comb begin
    nxt_out = out;
    nxt_up  = up;
    swept   = 1'b0;
    unique case (mode)
      M_BOUNCE: begin
        if (up && out[7]) begin
          nxt_out = out >> 1;
          nxt_up  = 1'b0;
        end else if (!up && out[0]) begin
          nxt_out = out << 1;
          nxt_up  = 1'b1;
        end else if (up) begin
          nxt_out = out << 1;
        end else begin
          nxt_out = out >> 1;
        end
        swept = (out == 8'h02) && (nxt_out == 8'h01);
      end
      M_WRAPL: begin
        nxt_out = {out[6:0], out[7]};
        swept   = (out == 8'h80);
      end
      M_WRAPR: begin
        nxt_out = {out[0], out[7:1]};
        swept   = (out == 8'h01);
      end
      M_HOLD: nxt_out = out;
    endcase
  end

  always_ff @(posedge ck) begin
    done <= 1'b0;
    if (res) begin
      state    <= IDLE;
      out      <= 8'h01;
      up       <= 1'b1;
      p        <= RESET_PERIOD;
      mode     <= M_BOUNCE;
      cnt      <= '0;
      sweeps   <= '0;
      n        <= '0;
      pend_p   <= '0;
      pend_m   <= '0;
      pend_p_v <= 1'b0;
      pend_m_v <= 1'b0;
    end else if (acc && cmd_op == OP_START) begin
      n      <= cmd_data;
      sweeps <= '0;
      cnt    <= '0;
      state  <= RUN;
      if (mode == M_BOUNCE || mode == M_WRAPL) begin
        out <= 8'h01;
        up  <= 1'b1;
      end else if (mode == M_WRAPR) begin
        out <= 8'h80;
      end
    end else if (acc && cmd_op == OP_STOP) begin
      if (state == RUN) begin
        state <= IDLE;
        cnt   <= '0;
      end
      if (pend_p_v) p <= pend_p;
      if (pend_m_v) mode <= pend_m;
      pend_p_v <= 1'b0;
      pend_m_v <= 1'b0;
    end else begin
      // Staged settings land on a tick, or at once when idle
      if (tick || state == IDLE) begin
        if (pend_p_v) p <= pend_p;
        if (pend_m_v) mode <= pend_m;
        pend_p_v <= 1'b0;
        pend_m_v <= 1'b0;
      end
      if (tick) begin
        cnt <= '0;
        out <= nxt_out;
        up  <= nxt_up;
        if (swept) begin
          sweeps <= sweeps + 16'd1;
          if (n != 16'd0 && sweeps + 16'd1 == n) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      end else if (state == RUN) begin
        cnt <= cnt + 16'd1;
      end
      if (acc && cmd_op == OP_PERIOD) begin
        if (state == RUN) begin
          pend_p_v <= 1'b1;
          pend_p   <= cmd_data;
        end else begin
          p <= cmd_data;
        end
      end
      if (acc && cmd_op == OP_MODE) begin
        if (state == RUN) begin
          pend_m_v <= 1'b1;
          pend_m   <= cmd_data[1:0];
        end else begin
          mode <= cmd_data[1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_knight_ctrl.sv
// Scoreboard bench for knight_ctrl: LED position/direction reference
// model feeds expected outputs to a negedge monitor.
module tb_knight_ctrl;

  logic        ck = 1'b0;
  logic        res = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = 16'd0;
  logic [7:0]  out;
  logic        busy;
  logic        done;

  always #5 ck = ~ck;

  knight_ctrl #(.RESET_PERIOD(16'd9)) dut (
    .ck(ck),
    .res(res),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .out(out),
    .busy(busy),
    .done(done)
  );

  // Reference model: LED as a position index 0..7 plus direction
  bit m_run, m_up, m_done, m_ppv, m_pmv;
  int m_cnt, m_p, m_mode, m_pos, m_sw, m_n, m_pp, m_pm;

  logic [10:0] q[$];
  int tests = 0;
  int fails = 0;
  int pushes = 0;

  function automatic logic [10:0] m_view();
    logic [7:0] o;
    o = 8'd1 << m_pos;
    return {o, m_run, m_done, !(m_ppv || m_pmv)};
  endfunction

  task automatic m_commit();
    if (m_ppv) m_p = m_pp;
    if (m_pmv) m_mode = m_pm;
    m_ppv = 0;
    m_pmv = 0;
  endtask

  task automatic m_tick();
    int old;
    bit sweep;
    old = m_pos;
    sweep = 0;
    case (m_mode)
      0: begin
        if (m_up) begin
          if (m_pos == 7) begin m_pos = 6; m_up = 0; end
          else m_pos = m_pos + 1;
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_up = 1; end
          else m_pos = m_pos - 1;
        end
        sweep = (old == 1) && (m_pos == 0);
      end
      1: begin m_pos = (m_pos + 1) % 8; sweep = (old == 7); end
      2: begin m_pos = (m_pos + 7) % 8; sweep = (old == 0); end
      default: ;
    endcase
    m_cnt = 0;
    if (sweep) begin
      m_sw = m_sw + 1;
      if (m_n != 0 && m_sw == m_n) begin
        m_done = 1;
        m_run = 0;
      end
    end
    m_commit();
  endtask

  task automatic m_step(input bit v, input int op, input int d, input bit r);
    bit was_run, acc;
    m_done = 0;
    if (r) begin
      m_run = 0; m_pos = 0; m_up = 1; m_p = 9; m_mode = 0;
      m_cnt = 0; m_sw = 0; m_n = 0; m_ppv = 0; m_pmv = 0;
      return;
    end
    was_run = m_run;
    acc = v && !(m_ppv || m_pmv);
    if (acc && op == 0) begin
      m_n = d; m_sw = 0; m_cnt = 0; m_run = 1;
      if (m_mode <= 1) begin m_pos = 0; m_up = 1; end
      else if (m_mode == 2) m_pos = 7;
    end else if (acc && op == 1) begin
      if (was_run) begin m_run = 0; m_cnt = 0; end
      m_commit();
    end else begin
      if (was_run && m_cnt == m_p) m_tick();
      else if (was_run) m_cnt = m_cnt + 1;
      else m_commit();
      if (acc && op == 2) begin
        if (was_run) begin m_ppv = 1; m_pp = d; end
        else m_p = d;
      end
      if (acc && op == 3) begin
        if (was_run) begin m_pmv = 1; m_pm = d % 4; end
        else m_mode = d % 4;
      end
    end
  endtask

  task automatic cyc(input bit v, input int op, input int d, input bit r);
    logic [10:0] e;
    cmd_valid = v;
    cmd_op = 2'(op);
    cmd_data = 16'(d);
    res = r;
    m_step(v, op, d, r);
    e = m_view();
    @(posedge ck);
    #1;
    q.push_back(e);
    pushes++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0);
  endtask

  always @(negedge ck) begin
    logic [10:0] e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {out, busy, done, cmd_ready};
      tests++;
      if (g !== e)
        begin
          fails++;
          $display("FAIL cycle t=%0t out/busy/done/ready got %h/%b/%b/%b want %h/%b/%b/%b",
                   $time, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
        end
    end
  end

  initial begin
    int op, d;
    bit v, r;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // P=0 bounce, one sweep
    cyc(1, 2, 0, 0);
    cyc(1, 0, 1, 0);
    idle(18);
    // P=3 wrap-left free-running, then STOP
    cyc(1, 2, 3, 0);
    cyc(1, 3, 1, 0);
    cyc(1, 0, 0, 0);
    idle(102);
    cyc(1, 1, 0, 0);
    idle(5);
    // Period change staged mid-interval
    cyc(1, 2, 9, 0);
    cyc(1, 3, 0, 0);
    cyc(1, 0, 0, 0);
    idle(4);
    cyc(1, 2, 1, 0);
    idle(14);
    cyc(1, 1, 0, 0);
    // Wrap-right, two sweeps
    cyc(1, 3, 2, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 0, 2, 0);
    idle(20);
    // STOP on the sweep-completing tick
    cyc(1, 3, 1, 0);
    cyc(1, 0, 1, 0);
    idle(7);
    cyc(1, 1, 0, 0);
    idle(3);
    // Reset with a pending SET_MODE
    cyc(1, 3, 2, 0);
    cyc(1, 2, 5, 0);
    cyc(1, 0, 0, 0);
    idle(3);
    cyc(1, 3, 1, 0);
    cyc(0, 0, 0, 1);
    idle(2);
    cyc(1, 0, 1, 0);
    idle(145);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 9) == 0);
      op = $urandom_range(0, 3);
      case (op)
        0: d = $urandom_range(0, 3);
        2: d = $urandom_range(0, 4);
        3: d = ($urandom_range(0, 65535) & 32'hfffc) | $urandom_range(0, 3);
        default: d = $urandom_range(0, 65535);
      endcase
      cyc(v, op, d, r);
    end
    cmd_valid = 0;
    @(negedge ck);
    #1;
    tests++;
    if (q.size() != 0 || tests != pushes + 1) begin
      fails++;
      $display("FAIL drain pending %0d checked %0d want 0 and %0d",
               q.size(), tests - 1, pushes);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
